instr_prefetch_buffer: RTL and testbench

Parametrised successor to the single-entry instruction register. A DEPTH-entry FIFO sits between memory-data return and the control FSM. It accepts fetched instruction words on a valid/ready handshake and holds them in order. The head entry is presented already sliced into opcode, function and register/offset fields, plus sign- and zero-extended immediates and a jump target. Fetch can run ahead of execution, and the queue can be flushed on a taken branch or jump.

---
 rtl/ir_pkg.sv | 39 +++
 rtl/ir_field_decode.sv | 45 ++++
 rtl/instr_prefetch_buffer.sv | 89 ++++++++
 tb/tb_instr_prefetch_buffer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - instruction field positions, opcodes and immediate helpers
package ir_pkg;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int RT_MSB   = 11;
  localparam int RT_LSB   = 8;
  localparam int RS_MSB   = 7;
  localparam int RS_LSB   = 4;
  localparam int FN_MSB   = 3;
  localparam int FN_LSB   = 0;
  localparam int SWLW_MSB = 11;
  localparam int SWLW_LSB = 10;
  localparam int OFF_MSB  = 9;
  localparam int OFF_LSB  = 8;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;
  localparam int JT_MSB   = 11;
  localparam int JT_LSB   = 0;

  localparam logic [3:0] ADD     = 4'b1000;
  localparam logic [3:0] ADDIMEX = 4'b1001;
  localparam logic [3:0] ADDIMZ  = 4'b1010;
  localparam logic [3:0] SUB     = 4'b1100;
  localparam logic [3:0] LW      = 4'b0001;
  localparam logic [3:0] SW      = 4'b0010;
  localparam logic [3:0] JMP     = 4'b0011;
  localparam logic [3:0] BE      = 4'b0100;
  localparam logic [3:0] BNE     = 4'b0101;

  function automatic logic [15:0] sign_ext8(input logic [7:0] imm);
    return {{8{imm[7]}}, imm};
  endfunction

  function automatic logic [15:0] zero_ext8(input logic [7:0] imm);
    return {8'h00, imm};
  endfunction

endpackage

// File: rtl/ir_field_decode.sv
// rtl/ir_field_decode.sv - combinational field slicer with immediate extension and valid gate
module ir_field_decode
  import ir_pkg::*;
(
  input  logic        valid,
  input  logic [15:0] instr,
  output logic [3:0]  OPCODE,
  output logic [3:0]  FUNCFIELD,
  output logic [3:0]  A_ReadReg1RT,
  output logic [3:0]  A_ReadReg2RT,
  output logic [1:0]  A_Offset,
  output logic [1:0]  A_RegSWLW,
  output logic [3:0]  A_WriteRegRT_BT,
  output logic [15:0] IMM_SX,
  output logic [15:0] IMM_ZX,
  output logic [11:0] JMP_TGT
);

  // slice the word into fields; everything reads as zero when no entry is present
  always_comb begin
    OPCODE          = '0;
    FUNCFIELD       = '0;
    A_ReadReg1RT    = '0;
    A_ReadReg2RT    = '0;
    A_Offset        = '0;
    A_RegSWLW       = '0;
    A_WriteRegRT_BT = '0;
    IMM_SX          = '0;
    IMM_ZX          = '0;
    JMP_TGT         = '0;
    if (valid) begin
      OPCODE          = instr[OPC_MSB:OPC_LSB];
      FUNCFIELD       = instr[FN_MSB:FN_LSB];
      A_ReadReg1RT    = instr[RS_MSB:RS_LSB];
      A_ReadReg2RT    = instr[FN_MSB:FN_LSB];
      A_Offset        = instr[OFF_MSB:OFF_LSB];
      A_RegSWLW       = instr[SWLW_MSB:SWLW_LSB];
      A_WriteRegRT_BT = instr[RT_MSB:RT_LSB];
      IMM_SX          = sign_ext8(instr[IMM_MSB:IMM_LSB]);
      IMM_ZX          = zero_ext8(instr[IMM_MSB:IMM_LSB]);
      JMP_TGT         = instr[JT_MSB:JT_LSB];
    end
  end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// rtl/instr_prefetch_buffer.sv - DEPTH-entry instruction prefetch FIFO with decoded head
module instr_prefetch_buffer
  import ir_pkg::*;
#(
  parameter int IW    = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] D_MemData,
  input  logic          C_IRWrite,
  output logic          in_ready,
  input  logic          C_IRAdvance,
  output logic          out_valid,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic [3:0]    OPCODE,
  output logic [3:0]    FUNCFIELD,
  output logic [3:0]    A_ReadReg1RT,
  output logic [3:0]    A_ReadReg2RT,
  output logic [1:0]    A_Offset,
  output logic [1:0]    A_RegSWLW,
  output logic [3:0]    A_WriteRegRT_BT,
  output logic [15:0]   IMM_SX,
  output logic [15:0]   IMM_ZX,
  output logic [11:0]   JMP_TGT
);

  localparam int AW = $clog2(DEPTH);

  logic [IW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push;
  logic          pop;
  logic [IW-1:0] head_word;

  // handshake status comes only from the registered occupancy
  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = C_IRWrite && in_ready;
  assign pop       = C_IRAdvance && out_valid;
  assign head_word = mem[rd_ptr];

  // storage write; contents are not cleared, occupancy decides what is visible
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem[wr_ptr] <= D_MemData;
    end
  end

  // pointers and occupancy: reset over flush over push/pop
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  ir_field_decode u_decode (
    .valid           (out_valid),
    .instr           (head_word[15:0]),
    .OPCODE          (OPCODE),
    .FUNCFIELD       (FUNCFIELD),
    .A_ReadReg1RT    (A_ReadReg1RT),
    .A_ReadReg2RT    (A_ReadReg2RT),
    .A_Offset        (A_Offset),
    .A_RegSWLW       (A_RegSWLW),
    .A_WriteRegRT_BT (A_WriteRegRT_BT),
    .IMM_SX          (IMM_SX),
    .IMM_ZX          (IMM_ZX),
    .JMP_TGT         (JMP_TGT)
  );

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb/tb_instr_prefetch_buffer.sv - self-checking bench for instr_prefetch_buffer
module tb_instr_prefetch_buffer;

  localparam int IW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [IW-1:0] D_MemData = '0;
  logic          C_IRWrite = 1'b0;
  logic          in_ready;
  logic          C_IRAdvance = 1'b0;
  logic          out_valid;
  logic          flush = 1'b0;
  logic [CW-1:0] count;
  logic [3:0]    OPCODE;
  logic [3:0]    FUNCFIELD;
  logic [3:0]    A_ReadReg1RT;
  logic [3:0]    A_ReadReg2RT;
  logic [1:0]    A_Offset;
  logic [1:0]    A_RegSWLW;
  logic [3:0]    A_WriteRegRT_BT;
  logic [15:0]   IMM_SX;
  logic [15:0]   IMM_ZX;
  logic [11:0]   JMP_TGT;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  logic [15:0] q[$];

  instr_prefetch_buffer #(.IW(IW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .D_MemData       (D_MemData),
    .C_IRWrite       (C_IRWrite),
    .in_ready        (in_ready),
    .C_IRAdvance     (C_IRAdvance),
    .out_valid       (out_valid),
    .flush           (flush),
    .count           (count),
    .OPCODE          (OPCODE),
    .FUNCFIELD       (FUNCFIELD),
    .A_ReadReg1RT    (A_ReadReg1RT),
    .A_ReadReg2RT    (A_ReadReg2RT),
    .A_Offset        (A_Offset),
    .A_RegSWLW       (A_RegSWLW),
    .A_WriteRegRT_BT (A_WriteRegRT_BT),
    .IMM_SX          (IMM_SX),
    .IMM_ZX          (IMM_ZX),
    .JMP_TGT         (JMP_TGT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // field value of word w at bit position lsb, nbits wide, by plain arithmetic
  function automatic int fld(input logic [15:0] w, input int lsb, input int nbits);
    return (int'(w) >> lsb) % (1 << nbits);
  endfunction

  function automatic int sx8(input logic [15:0] w);
    int v;
    v = int'(w) % 256;
    if (v >= 128) v = v - 256;
    return v & 32'hFFFF;
  endfunction

  // every cycle: DUT outputs against the queue model
  always @(negedge clk) begin
    if (chk_en) begin
      logic [15:0] h;
      int vld;
      vld = (q.size() > 0) ? 1 : 0;
      h = (vld != 0) ? q[0] : 16'h0000;
      chk("m_count",   32'(count),    32'(q.size()));
      chk("m_inready", 32'(in_ready), (q.size() < DEPTH) ? 1 : 0);
      chk("m_valid",   32'(out_valid), 32'(vld));
      chk("m_opcode",  32'(OPCODE),          32'(fld(h, 12, 4)));
      chk("m_func",    32'(FUNCFIELD),       32'(fld(h, 0, 4)));
      chk("m_rr1",     32'(A_ReadReg1RT),    32'(fld(h, 4, 4)));
      chk("m_rr2",     32'(A_ReadReg2RT),    32'(fld(h, 0, 4)));
      chk("m_off",     32'(A_Offset),        32'(fld(h, 8, 2)));
      chk("m_swlw",    32'(A_RegSWLW),       32'(fld(h, 10, 2)));
      chk("m_wr",      32'(A_WriteRegRT_BT), 32'(fld(h, 8, 4)));
      chk("m_sx",      32'(IMM_SX),          32'(sx8(h)));
      chk("m_zx",      32'(IMM_ZX),          32'(fld(h, 0, 8)));
      chk("m_jt",      32'(JMP_TGT),         32'(fld(h, 0, 12)));
    end
  end

  // one clock with the given inputs; the model follows the same edge
  task automatic cyc(input logic p, input logic [15:0] w, input logic a,
                     input logic f, input logic r);
    bit can_push;
    bit can_pop;
    C_IRWrite = p; D_MemData = w; C_IRAdvance = a; flush = f; rst = r;
    @(posedge clk);
    if (r || f) begin
      q.delete();
    end else begin
      can_push = (q.size() < DEPTH);
      can_pop  = (q.size() > 0);
      if (a && can_pop) void'(q.pop_front());
      if (p && can_push) q.push_back(w);
    end
    #1;
    C_IRWrite = 1'b0; D_MemData = '0; C_IRAdvance = 1'b0; flush = 1'b0; rst = 1'b0;
  endtask

  initial begin
    cyc(0, 16'h0, 0, 0, 1);
    chk_en = 1'b1;
    chk("rst_count", 32'(count), 0);
    chk("rst_inready", 32'(in_ready), 1);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_opcode", 32'(OPCODE), 0);

    cyc(1, 16'h8B48, 0, 0, 0);
    chk("t1_opcode", 32'(OPCODE), 8);
    chk("t1_func", 32'(FUNCFIELD), 8);
    chk("t1_rr1", 32'(A_ReadReg1RT), 4);
    chk("t1_rr2", 32'(A_ReadReg2RT), 8);
    chk("t1_off", 32'(A_Offset), 3);
    chk("t1_swlw", 32'(A_RegSWLW), 2);
    chk("t1_wr", 32'(A_WriteRegRT_BT), 32'hB);
    chk("t1_count", 32'(count), 1);

    cyc(1, 16'h2BC9, 1, 0, 0);
    chk("t2_sx", 32'(IMM_SX), 32'hFFC9);
    chk("t2_zx", 32'(IMM_ZX), 32'h00C9);
    chk("t2_jt", 32'(JMP_TGT), 32'hBC9);
    cyc(1, 16'h3B78, 0, 0, 0);
    cyc(0, 16'h0, 1, 0, 0);
    chk("t2_jt2", 32'(JMP_TGT), 32'hB78);
    cyc(0, 16'h0, 1, 0, 0);
    chk("t2_empty", 32'(out_valid), 0);

    for (int i = 1; i <= 5; i++) cyc(1, 16'(i * 16'h1111), 0, 0, 0);
    chk("t3_count", 32'(count), 4);
    chk("t3_inready", 32'(in_ready), 0);
    for (int i = 1; i <= 4; i++) begin
      chk("t3_order", 32'(JMP_TGT), 32'(i * 12'h111));
      cyc(0, 16'h0, 1, 0, 0);
    end
    chk("t3_drained", 32'(out_valid), 0);

    cyc(1, 16'h4321, 1, 0, 0);
    chk("pp_empty_count", 32'(count), 1);
    chk("pp_empty_jt", 32'(JMP_TGT), 32'h321);
    cyc(0, 16'h0, 1, 0, 0);

    cyc(1, 16'hA001, 0, 0, 0);
    cyc(1, 16'hA002, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 16'hB000 + 16'(i), 1, 0, 0);
      chk("t4_count", 32'(count), 2);
    end
    chk("t4_head", 32'(JMP_TGT), 32'h004);
    cyc(0, 16'h0, 1, 0, 0);
    chk("t4_next", 32'(JMP_TGT), 32'h005);
    cyc(0, 16'h0, 1, 0, 0);

    for (int i = 0; i < 4; i++) cyc(1, 16'hC0C0 + 16'(i), 0, 0, 0);
    cyc(1, 16'hD0D0, 1, 0, 0);
    chk("pp_full_count", 32'(count), 3);
    chk("pp_full_jt", 32'(JMP_TGT), 32'h0C1);

    cyc(1, 16'hEEEE, 0, 1, 0);
    chk("t5_count", 32'(count), 0);
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_inready", 32'(in_ready), 1);
    chk("t5_sx", 32'(IMM_SX), 0);
    chk("t5_jt", 32'(JMP_TGT), 0);

    for (int i = 0; i < 3; i++) cyc(1, 16'h7770 + 16'(i), 0, 0, 0);
    cyc(0, 16'h0, 1, 0, 1);
    chk("t6_count", 32'(count), 0);
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_opcode", 32'(OPCODE), 0);
    cyc(1, 16'hCB48, 0, 0, 0);
    chk("t6_opcode2", 32'(OPCODE), 32'hC);
    cyc(0, 16'h0, 0, 0, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
